// File: rtl/uart_rx_ctrl_if.sv
// rtl/uart_rx_ctrl_if.sv - drain-port stream of the UART receive controller FIFO
interface uart_rx_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_perr;
  logic              m_ready;

  modport master (output m_valid, output m_data, output m_perr, input m_ready);
  modport slave  (input m_valid, input m_data, input m_perr, output m_ready);
endinterface

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive controller: oversampling tick, parity pairing, frame FIFO, status
module uart_rx_ctrl #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int DIV_W  = 16
) (
  input  logic                       clk,
  input  logic                       Reset_n,
  input  logic                       enable,
  input  logic [DIV_W-1:0]           baud_div,
  output logic                       s_ticks,
  input  logic                       rx_done_tick,
  input  logic [DATA_W-1:0]          rx_data,
  input  logic                       rx_perr,
  uart_rx_ctrl_if.master             m_if,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overrun,
  output logic [7:0]                 perr_cnt,
  input  logic                       clr_status
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {ST_OFF, ST_RUN, ST_DRAIN} state_e;

  state_e            state_q;
  logic [DIV_W-1:0]  cnt_q;
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W:0]   mem_q [DEPTH];
  logic              perr_pend_q;
  logic              overrun_q;
  logic [7:0]        perr_cnt_q;

  logic frame, frame_perr, full, pop, push, drop, go_off;

  always_comb begin
    frame      = rx_done_tick && (state_q != ST_OFF);
    frame_perr = perr_pend_q | rx_perr;
    full       = (count_q == CW'(DEPTH));
    pop        = m_if.m_ready && (count_q != '0);
    // A full FIFO still takes the frame when the head leaves in the same cycle.
    push       = frame && (!full || pop);
    drop       = frame && full && !pop;
    go_off     = (state_q == ST_DRAIN) && !enable && (count_q == '0);
    count_d    = count_q;
    if (push && !pop)
      count_d = count_q + CW'(1);
    else if (pop && !push)
      count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_OFF:   if (enable) state_q <= ST_RUN;
        ST_RUN:   if (!enable) state_q <= ST_DRAIN;
        ST_DRAIN: begin
          if (enable)      state_q <= ST_RUN;
          else if (go_off) state_q <= ST_OFF;
        end
        default:  state_q <= ST_OFF;
      endcase
      // cnt above a freshly lowered divider restarts silently; equality is the tick.
      if (state_q == ST_RUN && cnt_q < baud_div)
        cnt_q <= cnt_q + DIV_W'(1);
      else
        cnt_q <= '0;
    end
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      perr_pend_q <= 1'b0;
      overrun_q   <= 1'b0;
      perr_cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {frame_perr, rx_data};
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;

      if (go_off || frame) perr_pend_q <= 1'b0;
      else if (rx_perr)    perr_pend_q <= 1'b1;

      if (drop)            overrun_q <= 1'b1;
      else if (clr_status) overrun_q <= 1'b0;

      if (frame && frame_perr) begin
        if (clr_status)              perr_cnt_q <= 8'd1;
        else if (perr_cnt_q != 8'hFF) perr_cnt_q <= perr_cnt_q + 8'd1;
      end else if (clr_status) begin
        perr_cnt_q <= '0;
      end
    end
  end

  assign s_ticks      = (state_q == ST_RUN) && (cnt_q == baud_div);
  assign m_if.m_valid = (count_q != '0);
  assign m_if.m_data  = mem_q[rd_ptr_q][DATA_W-1:0];
  assign m_if.m_perr  = mem_q[rd_ptr_q][DATA_W];
  assign fifo_count   = count_q;
  assign overrun      = overrun_q;
  assign perr_cnt     = perr_cnt_q;
endmodule
